control_unit: RTL and testbench

Multicycle control FSM for the 8-bit CPU. It sits directly upstream of the datapath: it consumes the 4-bit `opcode` and ALU zero indication the datapath produces, and drives every datapath control strobe plus the memory write enable. The outputs are Moore outputs, decoded from the state register only. Each instruction is two bytes: byte 1 goes to ir1 (opcode in [7:4], register in [3:0]) and byte 2 goes to ir2 (register in [7:4] or address).

---
 rtl/control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit
//   Multicycle control FSM for the 8-bit CPU. Each instruction is two bytes.
//   FETCH1 loads ir1 and FETCH2 loads ir2, and the PC increments through the
//   ALU in both states. DECODE then dispatches on the opcode, and the execute
//   state drives the datapath strobes for one cycle. Every output is a Moore
//   decode of registered state. This includes aluControl, which comes from a
//   copy of the opcode captured at the DECODE edge.
//
//   Optional feature macro: CU_BRANCH_EN
//     defined   : opcode 0x9 (JZ) branches to ir2 when zflag is set. zflag
//                 holds the ALU zero result of the last ALU instruction.
//     undefined : there is no JZ state and no zflag, and 0x9 is illegal.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous reset, active low
//   opcode[3:0]  in   ir1[7:4]; sampled only on the DECODE edge
//   aluZero      in   ALU result == 0; sampled only on the EXEC_ALU edge
//   pcSelect     out  PC source: 0 = ALU (pc+1), 1 = ir2
//   pcEnable     out  PC write enable
//   adrSelect    out  memory address: 0 = PC, 1 = ir2
//   ir1En/ir2En  out  instruction byte register enables
//   regSelect    out  register file read port select for the store path
//   wd3Select    out  register write data: 0 = memory, 1 = ALU
//   regWrite     out  register file write enable
//   op1Sel       out  ALU operand 1 select (1 = register)
//   op2Sel       out  ALU operand 2 select (1 = constant 1)
//   aluControl   out  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
//   memWrite     out  data memory write strobe
//   halted       out  high while in HALT
//   illegalOp    out  one-cycle pulse on an unrecognised opcode

module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       aluZero,
  output logic       pcSelect,
  output logic       pcEnable,
  output logic       adrSelect,
  output logic       ir1En,
  output logic       ir2En,
  output logic       regSelect,
  output logic       wd3Select,
  output logic       regWrite,
  output logic       op1Sel,
  output logic       op2Sel,
  output logic [2:0] aluControl,
  output logic       memWrite,
  output logic       halted,
  output logic       illegalOp
);

  // State encoding
  localparam logic [3:0] S_START    = 4'd0;
  localparam logic [3:0] S_FETCH1   = 4'd1;
  localparam logic [3:0] S_FETCH2   = 4'd2;
  localparam logic [3:0] S_DECODE   = 4'd3;
  localparam logic [3:0] S_EXEC_ALU = 4'd4;
  localparam logic [3:0] S_LOAD     = 4'd5;
  localparam logic [3:0] S_STORE    = 4'd6;
  localparam logic [3:0] S_JUMP     = 4'd7;
  localparam logic [3:0] S_ILLEGAL  = 4'd8;
  localparam logic [3:0] S_HALT     = 4'd9;
`ifdef CU_BRANCH_EN
  localparam logic [3:0] S_JZ       = 4'd10;
`endif

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Bundle of all control strobes, decoded from state
  typedef struct packed {
    logic       pc_sel;
    logic       pc_en;
    logic       adr_sel;
    logic       ir1_en;
    logic       ir2_en;
    logic       reg_sel;
    logic       wd3_sel;
    logic       reg_wr;
    logic       op1_sel;
    logic       op2_sel;
    logic [2:0] alu_ctl;
    logic       mem_wr;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  logic [3:0] state, nxt;
  logic [2:0] alu_op;   // ALU function latched at DECODE so EXEC_ALU stays Moore
  logic       zflag;
  ctrl_t      ctl;

  // State register and ALU function capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_START;
      alu_op <= ALU_ADD;
    end else begin
      state <= nxt;
      // For opcodes 1..5 this maps onto aluControl 000..100. For other
      // opcodes the value is never used.
      if (state == S_DECODE) alu_op <= opcode[2:0] - 3'd1;
    end
  end

`ifdef CU_BRANCH_EN
  // The zero flag is updated only by ALU instructions. Loads, stores and
  // jumps keep the value from the last ALU op.
  always_ff @(posedge clk) begin
    if (!reset)                    zflag <= 1'b0;
    else if (state == S_EXEC_ALU)  zflag <= aluZero;
  end
`else
  // The zero flag is not needed without the branch, so it is tied off.
  logic unused_aluzero;
  assign unused_aluzero = aluZero;
  assign zflag          = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    nxt = S_START;
    case (state)
      S_START:  nxt = S_FETCH1;
      S_FETCH1: nxt = S_FETCH2;
      S_FETCH2: nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOP:                                  nxt = S_FETCH1;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  nxt = S_EXEC_ALU;
          OP_LD:                                   nxt = S_LOAD;
          OP_ST:                                   nxt = S_STORE;
          OP_JMP:                                  nxt = S_JUMP;
`ifdef CU_BRANCH_EN
          OP_JZ:                                   nxt = S_JZ;
`endif
          OP_HALT:                                 nxt = S_HALT;
          default:                                 nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_ALU, S_LOAD, S_STORE, S_JUMP, S_ILLEGAL: nxt = S_FETCH1;
`ifdef CU_BRANCH_EN
      S_JZ:     nxt = S_FETCH1;
`endif
      S_HALT:   nxt = S_HALT;
      // An unused encoding recovers through START
      default:  nxt = S_START;
    endcase
  end

  // Moore output decode. Every field starts at 0 and each state sets only
  // the fields that differ.
  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH1: begin
        ctl.ir1_en  = 1'b1;
        ctl.op2_sel = 1'b1;
        ctl.pc_en   = 1'b1;
        ctl.alu_ctl = ALU_ADD;
      end
      S_FETCH2: begin
        ctl.ir2_en  = 1'b1;
        ctl.op2_sel = 1'b1;
        ctl.pc_en   = 1'b1;
        ctl.alu_ctl = ALU_ADD;
      end
      S_EXEC_ALU: begin
        ctl.op1_sel = 1'b1;
        ctl.wd3_sel = 1'b1;
        ctl.reg_wr  = 1'b1;
        ctl.alu_ctl = alu_op;
      end
      S_LOAD: begin
        ctl.adr_sel = 1'b1;
        ctl.reg_wr  = 1'b1;   // wd3Select stays 0, so memory data is written
      end
      S_STORE: begin
        ctl.adr_sel = 1'b1;
        ctl.reg_sel = 1'b1;
        ctl.mem_wr  = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_sel = 1'b1;
        ctl.pc_en  = 1'b1;
      end
`ifdef CU_BRANCH_EN
      S_JZ: begin
        ctl.pc_sel = 1'b1;
        ctl.pc_en  = zflag;   // zflag is a register, so the output is still Moore
      end
`endif
      S_ILLEGAL: ctl.illegal = 1'b1;
      S_HALT:    ctl.halt    = 1'b1;
      default:   ctl = '0;
    endcase
  end

  assign pcSelect   = ctl.pc_sel;
  assign pcEnable   = ctl.pc_en;
  assign adrSelect  = ctl.adr_sel;
  assign ir1En      = ctl.ir1_en;
  assign ir2En      = ctl.ir2_en;
  assign regSelect  = ctl.reg_sel;
  assign wd3Select  = ctl.wd3_sel;
  assign regWrite   = ctl.reg_wr;
  assign op1Sel     = ctl.op1_sel;
  assign op2Sel     = ctl.op2_sel;
  assign aluControl = ctl.alu_ctl;
  assign memWrite   = ctl.mem_wr;
  assign halted     = ctl.halt;
  assign illegalOp  = ctl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. All outputs are packed into one 16-bit
// vector, in this order:
//   pcSelect pcEnable adrSelect ir1En | ir2En regSelect wd3Select regWrite |
//   op1Sel op2Sel aluControl[2:1] | aluControl[0] memWrite halted illegalOp
// Each state's expected vector is written out by hand.
module tb_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       aluZero;
  logic       pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect;
  logic       wd3Select, regWrite, op1Sel, op2Sel, memWrite, halted, illegalOp;
  logic [2:0] aluControl;
  logic [15:0] obs;

  int checks = 0;
  int fails  = 0;

  localparam logic [15:0] V_ZERO = 16'b0000_0000_0000_0000;
  localparam logic [15:0] V_F1   = 16'b0101_0000_0100_0000;
  localparam logic [15:0] V_F2   = 16'b0100_1000_0100_0000;
  localparam logic [15:0] V_ADD  = 16'b0000_0011_1000_0000;
  localparam logic [15:0] V_SUB  = 16'b0000_0011_1000_1000;
  localparam logic [15:0] V_XOR  = 16'b0000_0011_1010_0000;
  localparam logic [15:0] V_LD   = 16'b0010_0001_0000_0000;
  localparam logic [15:0] V_ST   = 16'b0010_0100_0000_0100;
  localparam logic [15:0] V_JMP  = 16'b1100_0000_0000_0000;
  localparam logic [15:0] V_JZT  = 16'b1100_0000_0000_0000;
  localparam logic [15:0] V_JZN  = 16'b1000_0000_0000_0000;
  localparam logic [15:0] V_ILL  = 16'b0000_0000_0000_0001;
  localparam logic [15:0] V_HALT = 16'b0000_0000_0000_0010;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .aluZero(aluZero),
    .pcSelect(pcSelect), .pcEnable(pcEnable), .adrSelect(adrSelect),
    .ir1En(ir1En), .ir2En(ir2En), .regSelect(regSelect),
    .wd3Select(wd3Select), .regWrite(regWrite), .op1Sel(op1Sel),
    .op2Sel(op2Sel), .aluControl(aluControl), .memWrite(memWrite),
    .halted(halted), .illegalOp(illegalOp)
  );

  assign obs = {pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect,
                wd3Select, regWrite, op1Sel, op2Sel, aluControl, memWrite,
                halted, illegalOp};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: outputs=%b required=%b", tag, obs, exp);
    end
  endtask

  // Runs one instruction, starting in FETCH1 and ending back in FETCH1.
  // After entering the execute state, the opcode is changed to HALT. That
  // change must be ignored because opcode is sampled only at DECODE.
  task automatic instr(input logic [3:0] op, input logic az,
                       input logic [15:0] ex, input string tag);
    opcode = op;
    step(); chk({tag, "/fetch2"}, V_F2);
    step(); chk({tag, "/decode"}, V_ZERO);
    aluZero = az;
    if (op == 4'h0) begin
      step(); chk({tag, "/fetch1"}, V_F1);
    end else begin
      step(); chk({tag, "/exec"}, ex);
      opcode = 4'hF;
      step(); chk({tag, "/fetch1"}, V_F1);
    end
  endtask

  initial begin
    reset = 1'b0; opcode = 4'h0; aluZero = 1'b0;
    repeat (3) begin step(); chk("reset", V_ZERO); end
    reset = 1'b1;
    chk("start", V_ZERO);
    step(); chk("first_fetch1", V_F1);

    instr(4'h0, 1'b0, V_F1,  "nop");
    instr(4'h2, 1'b0, V_SUB, "sub");
    instr(4'h6, 1'b0, V_LD,  "ld");
    instr(4'h7, 1'b0, V_ST,  "st");
    instr(4'h8, 1'b0, V_JMP, "jmp");
    instr(4'hA, 1'b0, V_ILL, "illegal_a");
    instr(4'h1, 1'b0, V_ADD, "add");
    instr(4'h5, 1'b0, V_XOR, "xor");

`ifdef CU_BRANCH_EN
    instr(4'h2, 1'b1, V_SUB, "sub_z");
    instr(4'h6, 1'b0, V_LD,  "ld_keepz");
    instr(4'h9, 1'b0, V_JZT, "jz_taken");
    instr(4'h5, 1'b0, V_XOR, "xor_nz");
    instr(4'h9, 1'b1, V_JZN, "jz_not_taken");
`else
    instr(4'h9, 1'b0, V_ILL, "jz_illegal");
`endif

    // Reset in EXEC_ALU with aluZero=1. Reset must win, so zflag ends up 0.
    instr(4'h2, 1'b1, V_SUB, "sub_z2");
    opcode = 4'h2;
    step(); chk("rexec/fetch2", V_F2);
    step(); chk("rexec/decode", V_ZERO);
    aluZero = 1'b1;
    step(); chk("rexec/exec", V_SUB);
    reset = 1'b0;
    step(); chk("rexec/start", V_ZERO);
    reset = 1'b1;
    step(); chk("rexec/fetch1", V_F1);
`ifdef CU_BRANCH_EN
    instr(4'h9, 1'b0, V_JZN, "jz_after_reset");
`else
    instr(4'h9, 1'b0, V_ILL, "jz_after_reset");
`endif

    // Reset during FETCH2
    opcode = 4'h7;
    step(); chk("rf2/fetch2", V_F2);
    reset = 1'b0;
    step(); chk("rf2/start", V_ZERO);
    reset = 1'b1;
    step(); chk("rf2/fetch1", V_F1);

    // HALT is entered on the 4th cycle and held until reset
    opcode = 4'hF;
    step(); chk("halt/fetch2", V_F2);
    step(); chk("halt/decode", V_ZERO);
    step(); chk("halt/enter", V_HALT);
    for (int i = 0; i < 19; i++) begin
      step(); chk("halt/hold", V_HALT);
    end
    reset = 1'b0;
    step(); chk("halt/reset", V_ZERO);
    reset = 1'b1; opcode = 4'h0;
    step(); chk("halt/fetch1", V_F1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
